// File: rtl/mem_lsu_pkg.sv
// mem_lsu_pkg
// Shared definitions for the memory stage:
//   - alusel codes that mark an instruction as a load or a store
//   - aluop codes for the five loads and three stores
//   - FSM state encoding and the access-size encoding
//   - byte-enable width
//   - decodeOp()      : classifies an execute-stage op
//   - isMisaligned()  : alignment rule for half and word accesses
package mem_lsu_pkg;

  localparam int BE_W = 4;

  localparam logic [2:0] SEL_LOAD  = 3'b100;
  localparam logic [2:0] SEL_STORE = 3'b101;

  localparam logic [6:0] OP_LB  = 7'h20;
  localparam logic [6:0] OP_LH  = 7'h21;
  localparam logic [6:0] OP_LW  = 7'h22;
  localparam logic [6:0] OP_LBU = 7'h24;
  localparam logic [6:0] OP_LHU = 7'h25;
  localparam logic [6:0] OP_SB  = 7'h28;
  localparam logic [6:0] OP_SH  = 7'h29;
  localparam logic [6:0] OP_SW  = 7'h2A;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } lsuState_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } memSize_e;

  typedef struct packed {
    logic     isMem;
    logic     isLoad;
    logic     isSigned;
    memSize_e size;
  } memOp_t;

  // An unknown aluop under a load/store alusel is treated as non-memory,
  // so it simply flows through to writeback like any ALU result.
  function automatic memOp_t decodeOp(input logic [2:0] sel, input logic [6:0] op);
    memOp_t d;
    d.isMem    = 1'b0;
    d.isLoad   = 1'b0;
    d.isSigned = 1'b0;
    d.size     = SZ_WORD;
    if (sel == SEL_LOAD) begin
      d.isMem  = 1'b1;
      d.isLoad = 1'b1;
      case (op)
        OP_LB:   begin d.size = SZ_BYTE; d.isSigned = 1'b1; end
        OP_LH:   begin d.size = SZ_HALF; d.isSigned = 1'b1; end
        OP_LW:   d.size = SZ_WORD;
        OP_LBU:  d.size = SZ_BYTE;
        OP_LHU:  d.size = SZ_HALF;
        default: begin d.isMem = 1'b0; d.isLoad = 1'b0; end
      endcase
    end else if (sel == SEL_STORE) begin
      d.isMem = 1'b1;
      case (op)
        OP_SB:   d.size = SZ_BYTE;
        OP_SH:   d.size = SZ_HALF;
        OP_SW:   d.size = SZ_WORD;
        default: d.isMem = 1'b0;
      endcase
    end
    return d;
  endfunction

  function automatic logic isMisaligned(input memSize_e size, input logic [1:0] addrLow);
    return ((size == SZ_HALF) && addrLow[0]) ||
           ((size == SZ_WORD) && (addrLow != 2'b00));
  endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// mem_lsu_align
// Purely combinational byte-lane logic for the memory stage.
// Ports:
//   size_i       access size (byte/half/word)
//   isSigned_i   sign-extend loaded byte/half
//   addrLow_i    address bits [1:0]
//   storeData_i  raw store data (r2)
//   loadData_i   raw bus read data
//   byteEn_o     byte enables for the bus
//   storeSteer_o store data replicated onto every candidate lane
//   loadExt_o    selected lane, sign/zero extended to 32 bits
module mem_lsu_align
  import mem_lsu_pkg::*;
(
  input  memSize_e        size_i,
  input  logic            isSigned_i,
  input  logic [1:0]      addrLow_i,
  input  logic [31:0]     storeData_i,
  input  logic [31:0]     loadData_i,
  output logic [BE_W-1:0] byteEn_o,
  output logic [31:0]     storeSteer_o,
  output logic [31:0]     loadExt_o
);

  logic [7:0]  laneByte;
  logic [15:0] laneHalf;

  // Stores replicate the data so the slave can pick any lane via the byte
  // enables; loads pull the addressed lane down to bit 0 before extending.
  always_comb begin
    laneByte     = loadData_i[{addrLow_i, 3'b000} +: 8];
    laneHalf     = loadData_i[{addrLow_i[1], 4'b0000} +: 16];
    byteEn_o     = 4'b1111;
    storeSteer_o = storeData_i;
    loadExt_o    = loadData_i;
    case (size_i)
      SZ_BYTE: begin
        byteEn_o     = 4'b0001 << addrLow_i;
        storeSteer_o = {4{storeData_i[7:0]}};
        loadExt_o    = {{24{isSigned_i & laneByte[7]}}, laneByte};
      end
      SZ_HALF: begin
        byteEn_o     = 4'b0011 << addrLow_i;
        storeSteer_o = {2{storeData_i[15:0]}};
        loadExt_o    = {{16{isSigned_i & laneHalf[15]}}, laneHalf};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// mem_lsu
// Memory stage: issues loads/stores on a single-outstanding req/ack bus,
// registers the writeback triple and stalls upstream while an access is
// in flight.
// Ports:
//   clk_i, rst_ni                 clock, async active-low reset
//   wvalid_i/waddr_i/wdata_i      execute writeback triple
//   mem_addr_i, alusel_i, aluop_i effective address and op classification
//   r2_i                          store data
//   dbus_*_o / dbus_*_i           data bus request side / response side
//   stall_req_o                   hold upstream stages
//   wvalid_o/waddr_o/wdata_o      writeback triple to WB
//   misalign_o                    one-cycle fault pulse
// Optional feature: define MEM_TIMEOUT_EN to abort an access after
// TIMEOUT_CYCLES busy cycles without ack (reported on misalign_o).
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            wvalid_i,
  input  logic [4:0]      waddr_i,
  input  logic [31:0]     wdata_i,
  input  logic [31:0]     mem_addr_i,
  input  logic [2:0]      alusel_i,
  input  logic [6:0]      aluop_i,
  input  logic [31:0]     r2_i,
  output logic            dbus_req_o,
  output logic            dbus_we_o,
  output logic [31:0]     dbus_addr_o,
  output logic [BE_W-1:0] dbus_be_o,
  output logic [31:0]     dbus_wdata_o,
  input  logic [31:0]     dbus_rdata_i,
  input  logic            dbus_ack_i,
  output logic            stall_req_o,
  output logic            wvalid_o,
  output logic [4:0]      waddr_o,
  output logic [31:0]     wdata_o,
  output logic            misalign_o
);

  lsuState_e       state_q, state_d;
  logic            req_q, req_d, we_q, we_d;
  logic [31:0]     addr_q, addr_d, bwdata_q, bwdata_d;
  logic [BE_W-1:0] be_q, be_d;
  logic            wvalid_q, wvalid_d, misalign_q, misalign_d;
  logic [4:0]      waddr_q, waddr_d, accWaddr_q, accWaddr_d;
  logic [31:0]     wdata_q, wdata_d;
  memSize_e        accSize_q, accSize_d;
  logic            accSigned_q, accSigned_d, accLoad_q, accLoad_d;
  logic [1:0]      accLow_q, accLow_d;

  memOp_t          curOp;
  logic            curMis;
  memSize_e        alignSize;
  logic            alignSigned;
  logic [1:0]      alignLow;
  logic [BE_W-1:0] alignBe;
  logic [31:0]     alignSteer, alignLoad;
  logic            timeoutHit;

  assign curOp  = decodeOp(alusel_i, aluop_i);
  assign curMis = curOp.isMem && isMisaligned(curOp.size, mem_addr_i[1:0]);

  // One alignment block serves both phases: in IDLE it shapes the outgoing
  // request from the live inputs, in BUSY it extracts the load result
  // using the op details latched at the request edge.
  assign alignSize   = (state_q == ST_BUSY) ? accSize_q   : curOp.size;
  assign alignSigned = (state_q == ST_BUSY) ? accSigned_q : curOp.isSigned;
  assign alignLow    = (state_q == ST_BUSY) ? accLow_q    : mem_addr_i[1:0];

  mem_lsu_align u_align (
    .size_i       (alignSize),
    .isSigned_i   (alignSigned),
    .addrLow_i    (alignLow),
    .storeData_i  (r2_i),
    .loadData_i   (dbus_rdata_i),
    .byteEn_o     (alignBe),
    .storeSteer_o (alignSteer),
    .loadExt_o    (alignLoad)
  );

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The counter sits at zero in IDLE so it is already clear on entering
  // BUSY; it then counts busy cycles. Hitting TIMEOUT_CYCLES-1 without an
  // ack means this is the last busy cycle we are willing to wait.
  always_comb begin
    cnt_d = '0;
    if (state_q == ST_BUSY) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign timeoutHit = (state_q == ST_BUSY) && !dbus_ack_i &&
                      (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign timeoutHit = 1'b0;
`endif

  // Next-state and output decode. Bus registers hold by default so the
  // request stays stable for the whole BUSY phase; the writeback valid and
  // fault pulse default low so they only ever last one cycle.
  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    we_d        = we_q;
    addr_d      = addr_q;
    be_d        = be_q;
    bwdata_d    = bwdata_q;
    wvalid_d    = 1'b0;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;
    misalign_d  = 1'b0;
    accSize_d   = accSize_q;
    accSigned_d = accSigned_q;
    accLoad_d   = accLoad_q;
    accLow_d    = accLow_q;
    accWaddr_d  = accWaddr_q;
    stall_req_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        waddr_d = waddr_i;
        wdata_d = wdata_i;
        if (!curOp.isMem) begin
          wvalid_d = wvalid_i;
        end else if (curMis) begin
          misalign_d = 1'b1;
        end else begin
          stall_req_o = 1'b1;
          state_d     = ST_BUSY;
          req_d       = 1'b1;
          we_d        = !curOp.isLoad;
          addr_d      = {mem_addr_i[31:2], 2'b00};
          be_d        = alignBe;
          bwdata_d    = alignSteer;
          accSize_d   = curOp.size;
          accSigned_d = curOp.isSigned;
          accLoad_d   = curOp.isLoad;
          accLow_d    = mem_addr_i[1:0];
          accWaddr_d  = waddr_i;
        end
      end
      ST_BUSY: begin
        stall_req_o = !dbus_ack_i && !timeoutHit;
        if (dbus_ack_i) begin
          state_d  = ST_IDLE;
          req_d    = 1'b0;
          wvalid_d = accLoad_q;
          if (accLoad_q) begin
            waddr_d = accWaddr_q;
            wdata_d = alignLoad;
          end
        end else if (timeoutHit) begin
          state_d    = ST_IDLE;
          req_d      = 1'b0;
          misalign_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers. Reset abandons any access in flight, so a
  // late ack lands in IDLE where it is ignored.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      be_q        <= '0;
      bwdata_q    <= '0;
      wvalid_q    <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      misalign_q  <= 1'b0;
      accSize_q   <= SZ_BYTE;
      accSigned_q <= 1'b0;
      accLoad_q   <= 1'b0;
      accLow_q    <= '0;
      accWaddr_q  <= '0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      be_q        <= be_d;
      bwdata_q    <= bwdata_d;
      wvalid_q    <= wvalid_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      misalign_q  <= misalign_d;
      accSize_q   <= accSize_d;
      accSigned_q <= accSigned_d;
      accLoad_q   <= accLoad_d;
      accLow_q    <= accLow_d;
      accWaddr_q  <= accWaddr_d;
    end
  end

  assign dbus_req_o   = req_q;
  assign dbus_we_o    = we_q;
  assign dbus_addr_o  = addr_q;
  assign dbus_be_o    = be_q;
  assign dbus_wdata_o = bwdata_q;
  assign wvalid_o     = wvalid_q;
  assign waddr_o      = waddr_q;
  assign wdata_o      = wdata_q;
  assign misalign_o   = misalign_q;

endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu
// Self-checking bench for mem_lsu. The bench plays the data-bus slave and
// predicts every result from byte-lane arithmetic on the addresses and data.
// Build with MEM_TIMEOUT_EN defined to exercise the access-timeout abort.
`timescale 1ns/1ps
module tb_mem_lsu;
  import mem_lsu_pkg::*;

`ifdef MEM_TIMEOUT_EN
  localparam int TimeoutCycles = 4;
`else
  localparam int TimeoutCycles = 255;
`endif
  localparam logic [2:0] SelAlu = 3'b000;
  localparam logic [6:0] OpAdd  = 7'h01;

  logic        clk, rst_n;
  logic        wvalid, dbus_ack;
  logic [4:0]  waddr;
  logic [31:0] wdata, mem_addr, r2, dbus_rdata;
  logic [2:0]  alusel;
  logic [6:0]  aluop;
  logic        dbus_req, dbus_we, stall_req, wvalid_o, misalign_o;
  logic [31:0] dbus_addr, dbus_wdata, wdata_o;
  logic [3:0]  dbus_be;
  logic [4:0]  waddr_o;

  int checks = 0;
  int errors = 0;

  mem_lsu #(.TIMEOUT_CYCLES(TimeoutCycles)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .wvalid_i(wvalid), .waddr_i(waddr), .wdata_i(wdata),
    .mem_addr_i(mem_addr), .alusel_i(alusel), .aluop_i(aluop), .r2_i(r2),
    .dbus_req_o(dbus_req), .dbus_we_o(dbus_we), .dbus_addr_o(dbus_addr),
    .dbus_be_o(dbus_be), .dbus_wdata_o(dbus_wdata),
    .dbus_rdata_i(dbus_rdata), .dbus_ack_i(dbus_ack),
    .stall_req_o(stall_req), .wvalid_o(wvalid_o), .waddr_o(waddr_o),
    .wdata_o(wdata_o), .misalign_o(misalign_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  sel;
    logic [6:0]  op;
    logic        wv;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [31:0] addr;
    logic        expWv;
    logic        expMis;
  } vec_t;

  vec_t vecs[7];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] sel, input logic [6:0] op, input logic wv,
                               input logic [4:0] wa, input logic [31:0] wd,
                               input logic [31:0] addr, input logic [31:0] st);
    alusel = sel; aluop = op; wvalid = wv; waddr = wa; wdata = wd; mem_addr = addr; r2 = st;
  endtask

  task automatic bubble();
    applyStimulus(SelAlu, OpAdd, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0);
  endtask

  // Reference: an access of nb bytes at addr uses lanes addr%4 .. addr%4+nb-1.
  function automatic void refModel(input logic [6:0] op, input logic [31:0] addr,
                                   input logic [31:0] st, input logic [31:0] rdata,
                                   output bit isLoad, output bit mis, output logic [3:0] be,
                                   output logic [31:0] bw, output logic [31:0] res);
    int nb, lane;
    bit sgn;
    logic [31:0] mask, v;
    isLoad = (op == OP_LB) || (op == OP_LH) || (op == OP_LW) || (op == OP_LBU) || (op == OP_LHU);
    sgn    = (op == OP_LB) || (op == OP_LH);
    nb     = (op == OP_LB || op == OP_LBU || op == OP_SB) ? 1 :
             (op == OP_LH || op == OP_LHU || op == OP_SH) ? 2 : 4;
    lane   = int'(addr % 4);
    mis    = (addr % nb) != 0;
    mask   = (nb == 4) ? 32'hFFFF_FFFF : (32'h1 << (8 * nb)) - 32'h1;
    be     = 4'(((1 << nb) - 1) << lane);
    bw     = (st & mask) * ((nb == 1) ? 32'h0101_0101 : (nb == 2) ? 32'h0001_0001 : 32'h1);
    v      = (rdata >> (8 * lane)) & mask;
    if (sgn && v[8 * nb - 1]) v = v | ~mask;
    res    = v;
  endfunction

  // Issue one memory op from IDLE, act as slave with 'waits' wait cycles,
  // and check the request, the stall length and the writeback.
  task automatic runMemOp(input logic [6:0] op, input logic [31:0] addr, input logic [31:0] st,
                          input logic [4:0] wa, input int waits, input logic [31:0] rdata);
    bit isLoad, mis;
    logic [3:0] be;
    logic [31:0] bw, res;
    int stallCnt;
    refModel(op, addr, st, rdata, isLoad, mis, be, bw, res);
    applyStimulus(isLoad ? SEL_LOAD : SEL_STORE, op, 1'b1, wa, $urandom, addr, st);
    #1;
    checkOutput("issue stall", stall_req, !mis);
    stallCnt = int'(stall_req);
    @(posedge clk); #1;
    bubble();
    if (mis) begin
      checkOutput("misalign pulse", misalign_o, 1);
      checkOutput("misalign no req", dbus_req, 0);
      checkOutput("misalign wvalid", wvalid_o, 0);
      return;
    end
    checkOutput("req", dbus_req, 1);
    checkOutput("we", dbus_we, !isLoad);
    checkOutput("addr", dbus_addr, addr & 32'hFFFF_FFFC);
    checkOutput("be", dbus_be, be);
    if (!isLoad) checkOutput("store data", dbus_wdata, bw);
    checkOutput("bubble wvalid", wvalid_o, 0);
    repeat (waits) begin
      dbus_ack = 1'b0;
      #1;
      stallCnt += int'(stall_req);
      @(posedge clk); #1;
    end
    checkOutput("req held", dbus_req, 1);
    dbus_ack = 1'b1;
    dbus_rdata = rdata;
    #1;
    stallCnt += int'(stall_req);
    @(posedge clk); #1;
    dbus_ack = 1'b0;
    dbus_rdata = $urandom;
    checkOutput("stall cycles", stallCnt, waits + 1);
    checkOutput("req dropped", dbus_req, 0);
    checkOutput("wb valid", wvalid_o, isLoad);
    if (isLoad) begin
      checkOutput("wb addr", waddr_o, wa);
      checkOutput("wb data", wdata_o, res);
    end
  endtask

  logic [6:0] memOps[8] = '{OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW};

  initial begin
    int stallCnt, reqCycles;
    logic [31:0] a;
    vecs[0] = '{SelAlu,    OpAdd, 1'b1, 5'd5,  32'h1234_5678, 32'h0,    1'b1, 1'b0};
    vecs[1] = '{SEL_LOAD,  OP_LW, 1'b1, 5'd6,  32'h0,         32'h3001, 1'b0, 1'b1};
    vecs[2] = '{SelAlu,    OpAdd, 1'b0, 5'd9,  32'hDEAD_BEEF, 32'h0,    1'b0, 1'b0};
    vecs[3] = '{SEL_LOAD,  OP_LH, 1'b1, 5'd1,  32'h0,         32'h2001, 1'b0, 1'b1};
    vecs[4] = '{SEL_STORE, OP_SW, 1'b1, 5'd2,  32'h0,         32'h1002, 1'b0, 1'b1};
    vecs[5] = '{SelAlu,    OpAdd, 1'b1, 5'd31, 32'hCAFE_0001, 32'h0,    1'b1, 1'b0};
    vecs[6] = '{SEL_STORE, OP_SH, 1'b1, 5'd3,  32'h0,         32'h4003, 1'b0, 1'b1};

    rst_n = 1'b0; dbus_ack = 1'b0; dbus_rdata = '0;
    bubble();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("reset req", dbus_req, 0);
    checkOutput("reset wvalid", wvalid_o, 0);
    checkOutput("reset misalign", misalign_o, 0);

    // Reset while BUSY abandons the access; a later ack is ignored.
    applyStimulus(SEL_LOAD, OP_LW, 1'b1, 5'd7, 32'h0, 32'h40, 32'h0);
    @(posedge clk); #1;
    bubble();
    checkOutput("t1 req before reset", dbus_req, 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t1 req", dbus_req, 0);
    checkOutput("t1 we", dbus_we, 0);
    checkOutput("t1 addr", dbus_addr, 0);
    checkOutput("t1 be", dbus_be, 0);
    checkOutput("t1 wdata bus", dbus_wdata, 0);
    checkOutput("t1 wvalid", wvalid_o, 0);
    checkOutput("t1 waddr", waddr_o, 0);
    checkOutput("t1 wdata", wdata_o, 0);
    checkOutput("t1 stall", stall_req, 0);
    #2 rst_n = 1'b1;
    dbus_ack = 1'b1; dbus_rdata = 32'h5555_AAAA;
    @(posedge clk); #1;
    dbus_ack = 1'b0;
    checkOutput("t1 late ack wvalid", wvalid_o, 0);
    checkOutput("t1 late ack req", dbus_req, 0);

    // Single-cycle vectors: ALU pass-through and misaligned accesses.
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].sel, vecs[i].op, vecs[i].wv, vecs[i].wa, vecs[i].wd, vecs[i].addr, 32'h0);
      #1;
      checkOutput($sformatf("vec%0d stall", i), stall_req, 0);
      @(posedge clk); #1;
      checkOutput($sformatf("vec%0d wvalid", i), wvalid_o, vecs[i].expWv);
      checkOutput($sformatf("vec%0d misalign", i), misalign_o, vecs[i].expMis);
      checkOutput($sformatf("vec%0d req", i), dbus_req, 0);
      if (vecs[i].expWv) begin
        checkOutput($sformatf("vec%0d waddr", i), waddr_o, vecs[i].wa);
        checkOutput($sformatf("vec%0d wdata", i), wdata_o, vecs[i].wd);
      end
    end
    bubble();
    @(posedge clk); #1;
    checkOutput("misalign one cycle", misalign_o, 0);

    // op_lb at 0x1003 with two wait cycles.
    applyStimulus(SEL_LOAD, OP_LB, 1'b1, 5'd9, 32'h0, 32'h1003, 32'h0);
    #1;
    stallCnt = int'(stall_req);
    @(posedge clk); #1;
    bubble();
    checkOutput("t3 addr", dbus_addr, 32'h1000);
    checkOutput("t3 be", dbus_be, 4'b1000);
    checkOutput("t3 we", dbus_we, 0);
    repeat (2) begin
      #1; stallCnt += int'(stall_req);
      @(posedge clk); #1;
    end
    dbus_ack = 1'b1; dbus_rdata = 32'h80FF_0000;
    #1; stallCnt += int'(stall_req);
    @(posedge clk); #1;
    dbus_ack = 1'b0;
    checkOutput("t3 stall cycles", stallCnt, 3);
    checkOutput("t3 wvalid", wvalid_o, 1);
    checkOutput("t3 waddr", waddr_o, 9);
    checkOutput("t3 wdata", wdata_o, 32'hFFFF_FF80);

    // Store half, then back-to-back accesses through the shared helper.
    runMemOp(OP_SH, 32'h2002, 32'hABCD_1234, 5'd4, 0, 32'h0);
    runMemOp(OP_LHU, 32'h2002, 32'h0, 5'd8, 1, 32'h8001_7FFF);
    runMemOp(OP_LH, 32'h2000, 32'h0, 5'd10, 0, 32'h1234_8001);
    runMemOp(OP_LW, 32'h3001, 32'h0, 5'd11, 0, 32'h0);

`ifdef MEM_TIMEOUT_EN
    applyStimulus(SEL_LOAD, OP_LW, 1'b1, 5'd3, 32'h0, 32'h500, 32'h0);
    @(posedge clk); #1;
    bubble();
    reqCycles = 0;
    while (dbus_req === 1'b1 && reqCycles < 50) begin
      reqCycles++;
      if (reqCycles == TimeoutCycles) begin
        #1;
        checkOutput("t6 stall released", stall_req, 0);
      end
      @(posedge clk); #1;
    end
    checkOutput("t6 busy cycles", reqCycles, TimeoutCycles);
    checkOutput("t6 fault pulse", misalign_o, 1);
    checkOutput("t6 wvalid", wvalid_o, 0);
    checkOutput("t6 stall idle", stall_req, 0);
    @(posedge clk); #1;
    checkOutput("t6 pulse ends", misalign_o, 0);
`else
    applyStimulus(SEL_LOAD, OP_LW, 1'b1, 5'd3, 32'h0, 32'h500, 32'h0);
    @(posedge clk); #1;
    bubble();
    repeat (12) @(posedge clk);
    #1;
    checkOutput("no timeout req", dbus_req, 1);
    checkOutput("no timeout stall", stall_req, 1);
    dbus_ack = 1'b1; dbus_rdata = 32'h0BAD_F00D;
    @(posedge clk); #1;
    dbus_ack = 1'b0;
    checkOutput("no timeout result", wdata_o, 32'h0BAD_F00D);
`endif

    // Randomized mix of memory and ALU ops, issued back-to-back.
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 9) >= 8) begin
        logic [31:0] d;
        logic [4:0] w;
        d = $urandom;
        w = 5'($urandom_range(0, 31));
        applyStimulus(SelAlu, OpAdd, 1'b1, w, d, $urandom, $urandom);
        @(posedge clk); #1;
        checkOutput("rand alu wvalid", wvalid_o, 1);
        checkOutput("rand alu wdata", wdata_o, d);
      end else begin
        a = $urandom;
        if ($urandom_range(0, 2) != 0) a[1:0] = 2'b00;
        if ($urandom_range(0, 1) != 0) a[0] = 1'b0;
        runMemOp(memOps[$urandom_range(0, 7)], a, $urandom, 5'($urandom_range(0, 31)),
                 int'($urandom_range(0, 3)), $urandom);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- Memory stage, directly downstream of the execute stage.
- Consumes execute outputs: wvalid, waddr, wdata, mem_addr, alusel, aluop, r2.
- Performs load/store accesses on a single-outstanding request/ack data bus, with byte-lane steering and load sign/zero extension.
- Registers the writeback triple for the WB stage and stalls the pipeline while an access is in flight.

Parameters:
- TIMEOUT_CYCLES, 255: cycles waited for dbus_ack before abort (used only with the optional feature).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- wvalid  in  1  execute writeback enable
- waddr  in  5  execute destination register
- wdata  in  32  execute ALU result
- mem_addr  in  32  execute effective address
- alusel  in  3  execute unit select (load/store/other)
- aluop  in  7  execute operation code
- r2  in  32  store data
- dbus_req  out  1  bus request
- dbus_we  out  1  1 = write
- dbus_addr  out  32  word address, bits [1:0] = 0
- dbus_be  out  4  byte enables
- dbus_wdata  out  32  lane-steered store data
- dbus_rdata  in  32  read data, valid with ack
- dbus_ack  in  1  access complete
- stall_req  out  1  hold upstream stages
- wvalid_o  out  1  WB enable
- waddr_o  out  5  WB register
- wdata_o  out  32  WB data
- misalign_o  out  1  one-cycle pulse on a misaligned access

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM to IDLE.
  - dbus_req, dbus_we = 0; dbus_addr, dbus_wdata = 0; dbus_be = 0.
  - wvalid_o = 0, waddr_o = 0, wdata_o = 0, misalign_o = 0.
  - A reset mid-access abandons the access; a late ack is ignored.
- Ops: loads op_lb/op_lh/op_lw/op_lbu/op_lhu under alusel=load; stores op_sb/op_sh/op_sw under alusel=store. Any other alusel is non-memory.
- Non-memory op in IDLE: wvalid_o/waddr_o/wdata_o register the inputs, 1-cycle latency.
- Misaligned access: half with addr[0]=1, or word with addr[1:0]!=0.
  - No bus access.
  - misalign_o=1 for one cycle; wvalid_o=0; no stall.
- FSM states IDLE, BUSY.
  - IDLE, aligned memory op:
    - stall_req=1 combinationally; wvalid_o registers 0 (bubble).
    - At the edge, latch op/waddr/addr-low bits, go to BUSY.
    - Assert registered dbus_req, dbus_we, dbus_addr={addr[31:2],2'b00}, dbus_be, dbus_wdata.
  - BUSY:
    - Bus signals held stable; inputs ignored (upstream is stalled).
    - stall_req = !dbus_ack.
  - BUSY and dbus_ack: drop dbus_req next edge, return to IDLE.
    - Load: wvalid_o=1, waddr_o=latched waddr, wdata_o=extended data.
    - Store: wvalid_o=0.
- Minimum memory-op latency: 2 cycles (request edge, then ack edge). Each extra wait cycle adds one.
- Byte enables:
  - byte: 4'b0001<<addr[1:0]
  - half: 4'b0011<<addr[1:0]
  - word: 4'b1111
- dbus_wdata: byte replicated x4; half replicated x2; word as-is.
- Load extraction:
  - byte = rdata[8*addr[1:0]+:8]; half = rdata[16*addr[1]+:16].
  - op_lb/op_lh sign-extend; op_lbu/op_lhu zero-extend.
- dbus_ack in IDLE is ignored.
- Back-to-back memory ops: a second op is accepted in the cycle IDLE is re-entered.

Optional Feature:
- MEM_TIMEOUT_EN defined:
  - An 8+ bit counter runs in BUSY and clears on entering BUSY.
  - When it reaches TIMEOUT_CYCLES without ack: drop dbus_req, go to IDLE, release stall, wvalid_o=0, pulse misalign_o for one cycle as a generic access fault.
- Undefined: no counter; BUSY waits indefinitely.

Decomposition:
- define.v holds:
  - op_lb..op_sw codes and the load/store alusel codes.
  - FSM state encodings st_idle/st_busy.
  - Byte-enable width constant.
- One sub-module, lsu_align: purely combinational byte-enable/store-steer/load-extract logic, instanced once; the FSM and registers stay in mem_lsu.

Test Plan:
1. Reset mid-BUSY (req=1) by pulling rst low between edges -> dbus_req=0 and all outputs 0 immediately; a subsequent ack produces no writeback.
2. op_add, wdata=0x12345678, waddr=5 -> next cycle wvalid_o=1, waddr_o=5, wdata_o=0x12345678, stall_req=0.
3. op_lb, addr 0x1003, rdata=0x80FF_0000, ack after 2 wait cycles:
   - Request: dbus_addr=0x1000, be=4'b1000.
   - Result: wdata_o=0xFFFFFF80; stall held for exactly 3 cycles.
4. op_sh, addr 0x2002, r2=0xABCD1234 -> be=4'b1100, dbus_wdata=0x12341234, we=1; after ack wvalid_o=0.
5. op_lw, addr 0x3001 -> no dbus_req, misalign_o pulse, wvalid_o=0.
6. With MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> req dropped after 4 BUSY cycles, fault pulse, stall released.
